// File: rtl/fifo_arbiter_if.sv
// Handshake bundle between fifo_arbiter and the eight FIFOs around it.
// Valid/ready semantics: an input FIFO pops when its rd_en bit is high at a
// rising edge and presents that word on its in_data slice during the next
// cycle. A destination FIFO pushes out_data when its wr_en bit is high at a
// rising edge. out_almost_full acts as the destination-side ready (low means
// ready), and in_empty low acts as the source-side valid.
interface fifo_arbiter_if #(
   parameter int DATA_W = 10,
   parameter int N_CH   = 4
);
   logic [N_CH-1:0]        in_empty;
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        out_almost_full;
   logic [N_CH-1:0]        rd_en;
   logic [N_CH-1:0]        wr_en;
   logic [DATA_W-1:0]      out_data;

   // Arbiter side
   modport master (
      input  in_empty, in_data, out_almost_full,
      output rd_en, wr_en, out_data
   );

   // FIFO side
   modport slave (
      output in_empty, in_data, out_almost_full,
      input  rd_en, wr_en, out_data
   );
endinterface

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: pops one word per cycle from four input FIFOs, routes it by
// word[DATA_W-1:DATA_W-2] to one of four destination FIFOs, sequences
// RESET/INIT/IDLE/ACTIVE and distributes the almost-full/empty thresholds.
// Rd-to-wr latency is fixed at 2 cycles; at most 2 words are in flight.
// Optional macro ARB_STRICT_PRIO_EN: fixed priority (input 0 highest)
// replaces round-robin arbitration.
module fifo_arbiter #(
   parameter int DATA_W = 10,
   parameter int N_CH   = 4,
   parameter int TH_W   = 3
) (
   input  logic                clk,
   input  logic                reset_L,
   input  logic                init,
   input  logic [TH_W-1:0]     umbral_af_in,
   input  logic [TH_W-1:0]     umbral_ae_in,
   fifo_arbiter_if.master      bus,
   output logic [TH_W-1:0]     umbral_af_out,
   output logic [TH_W-1:0]     umbral_ae_out,
   output logic [1:0]          state,
   output logic                idle
);

   // The destination field is 2 bits, so the channel select is 2 bits.
   localparam int SEL_W = 2;

   typedef enum logic [1:0] {
      S_RESET  = 2'd0,
      S_INIT   = 2'd1,
      S_IDLE   = 2'd2,
      S_ACTIVE = 2'd3
   } state_t;

   state_t              state_q;
   logic [N_CH-1:0]     rd;
   logic [SEL_W-1:0]    win;
   logic                found;
   logic                grant_ok;
   logic                grant;
   logic                v1;        // word popped last cycle, now on its slice
   logic                v2;        // word registered, wr_en pulse this cycle
   logic [SEL_W-1:0]    sel1;
   logic [DATA_W-1:0]   word1;
   logic [N_CH-1:0]     wr_q;
   logic [DATA_W-1:0]   data_q;
`ifndef ARB_STRICT_PRIO_EN
   logic [SEL_W-1:0]    rr_last;
   logic [SEL_W-1:0]    idx;
`endif

   // Grant selection: global backpressure and init both block every grant.
   always_comb begin
      grant_ok = (state_q == S_ACTIVE) && !init && (bus.out_almost_full == '0);
      found    = 1'b0;
      win      = '0;
`ifdef ARB_STRICT_PRIO_EN
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (!bus.in_empty[i]) begin
            found = 1'b1;
            win   = SEL_W'(i);
         end
      end
`else
      idx = '0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = rr_last + SEL_W'(k);
         if (!found && !bus.in_empty[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
`endif
      rd = '0;
      if (grant_ok && found) begin
         rd[win] = 1'b1;
      end
   end

   assign grant      = |rd;
   assign bus.rd_en  = rd;
   assign word1      = bus.in_data[int'(sel1) * DATA_W +: DATA_W];

   // Control FSM with threshold registers; thresholds load only in INIT.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q       <= S_RESET;
         umbral_af_out <= '0;
         umbral_ae_out <= '0;
      end else begin
         case (state_q)
            S_RESET: state_q <= S_INIT;
            S_INIT: begin
               umbral_af_out <= umbral_af_in;
               umbral_ae_out <= umbral_ae_in;
               if (!init) state_q <= S_IDLE;
            end
            S_IDLE: begin
               if (init)                     state_q <= S_INIT;
               else if (bus.in_empty != '1)  state_q <= S_ACTIVE;
            end
            S_ACTIVE: begin
               if (init)                     state_q <= S_INIT;
               else if (bus.in_empty == '1)  state_q <= S_IDLE;
            end
            default: state_q <= S_RESET;
         endcase
      end
   end

   // Two-stage data path: remember who was popped, then register the word
   // and decode its destination into a single-cycle wr_en pulse.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         sel1   <= '0;
         wr_q   <= '0;
         data_q <= '0;
      end else begin
         v1 <= grant;
         v2 <= v1;
         if (grant) sel1 <= win;
         if (v1) begin
            data_q <= word1;
            wr_q   <= {{(N_CH-1){1'b0}}, 1'b1} << word1[DATA_W-1 -: SEL_W];
         end else begin
            wr_q   <= '0;
         end
      end
   end

`ifndef ARB_STRICT_PRIO_EN
   // Round-robin pointer: remembers the last winner; 3 makes input 0 first.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)   rr_last <= 2'd3;
      else if (grant) rr_last <= win;
   end
`endif

   assign bus.wr_en    = wr_q;
   assign bus.out_data = data_q;
   assign state        = state_q;
   assign idle         = (state_q == S_IDLE) && !v1 && !v2;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: behavioural input FIFOs, a write scoreboard with
// an expected queue, a table of FSM/threshold vectors and directed sequences.
module tb_fifo_arbiter;
   localparam int DATA_W = 10;
   localparam int N_CH   = 4;
   localparam int TH_W   = 3;
   localparam int DEPTH  = 32;

   typedef struct {
      logic            init;
      logic [TH_W-1:0] af;
      logic [TH_W-1:0] ae;
      logic [1:0]      exp_state;
      logic [TH_W-1:0] exp_af;
      logic [TH_W-1:0] exp_ae;
      logic            exp_idle;
   } vec_t;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            reset_L;
   logic            init;
   logic [TH_W-1:0] af_in, ae_in, af_out, ae_out;
   logic [1:0]      state;
   logic            idle;

   fifo_arbiter_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

   fifo_arbiter #(.DATA_W(DATA_W), .N_CH(N_CH), .TH_W(TH_W)) dut (
      .clk           (clk),
      .reset_L       (reset_L),
      .init          (init),
      .umbral_af_in  (af_in),
      .umbral_ae_in  (ae_in),
      .bus           (bus),
      .umbral_af_out (af_out),
      .umbral_ae_out (ae_out),
      .state         (state),
      .idle          (idle)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- input FIFO models ----------------
   logic [DATA_W-1:0] src_mem [N_CH][DEPTH];
   int                src_wr  [N_CH] = '{default: 0};
   int                src_rd  [N_CH] = '{default: 0};
   logic [DATA_W-1:0] dreg    [N_CH] = '{default: '0};

   for (genvar g = 0; g < N_CH; g++) begin : g_fifo
      assign bus.in_empty[g] = (src_rd[g] == src_wr[g]);
      assign bus.in_data[g*DATA_W +: DATA_W] = dreg[g];
   end

   always @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (bus.rd_en[i] && (src_rd[i] != src_wr[i])) begin
            dreg[i]   <= src_mem[i][src_rd[i] % DEPTH];
            src_rd[i] <= src_rd[i] + 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push(input int ch, input logic [DATA_W-1:0] w);
      src_mem[ch][src_wr[ch] % DEPTH] = w;
      src_wr[ch]++;
   endtask

   function automatic logic [DATA_W-1:0] mk_word(input int dest);
      return {2'(dest), 8'($urandom_range(0, 255))};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [DATA_W-1:0] exp_q[$];
   int                due_q[$];
   int                grant_log[$];
   int                grant_cyc[$];
   int                wr_count = 0;

   always @(negedge clk) begin
      logic [DATA_W-1:0] w;
      logic [N_CH-1:0]   e_wr;
      if (!reset_L) begin
         exp_q.delete();
         due_q.delete();
      end else begin
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            w    = exp_q.pop_front();
            void'(due_q.pop_front());
            e_wr = 4'b0001 << w[DATA_W-1 -: 2];
            check("wr_en", 32'(bus.wr_en), 32'(e_wr));
            check("out_data", 32'(bus.out_data), 32'(w));
            wr_count++;
         end else if (bus.wr_en != '0) begin
            check("wr_en_unexpected", 32'(bus.wr_en), 32'd0);
         end
         if (bus.rd_en != '0) begin
            check("rd_en_onehot", 32'($countones(bus.rd_en)), 32'd1);
            for (int i = 0; i < N_CH; i++) begin
               if (bus.rd_en[i]) begin
                  if (bus.in_empty[i]) begin
                     check("rd_en_on_empty", 32'(bus.in_empty[i]), 32'd0);
                  end else begin
                     exp_q.push_back(src_mem[i][src_rd[i] % DEPTH]);
                     due_q.push_back(cyc + 2);
                     grant_log.push_back(i);
                     grant_cyc.push_back(cyc);
                  end
               end
            end
         end
      end
   end

   // Waits until `target` grants have been logged and the DUT reports idle.
   task automatic wait_done(input int target, input string name);
      int k = 0;
      while ((grant_log.size() < target || idle !== 1'b1) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check({name, "_grants"}, 32'(grant_log.size()), 32'(target));
      check({name, "_idle"}, 32'(idle), 32'd1);
   endtask

   task automatic wait_grants(input int target, input string name);
      int k = 0;
      while (grant_log.size() < target && k < 200) begin
         @(posedge clk);
         k++;
      end
      #1;
      check({name, "_reach"}, 32'(grant_log.size() >= target), 32'd1);
   endtask

   task automatic check_order(input string name, input int base, input int ord[8], input int n);
      for (int k = 0; k < n; k++) begin
         check(name, (base + k < grant_log.size()) ? 32'(grant_log[base + k]) : 32'hFFFF_FFFF,
               32'(ord[k]));
      end
   endtask

   // ---------------- stimulus ----------------
   vec_t vecs[8];
   int   gb, wc;

   initial begin
      vecs[0] = '{1'b1, 3'd6, 3'd1, 2'd1, 3'd0, 3'd0, 1'b0};
      vecs[1] = '{1'b1, 3'd6, 3'd1, 2'd1, 3'd6, 3'd1, 1'b0};
      vecs[2] = '{1'b0, 3'd6, 3'd1, 2'd2, 3'd6, 3'd1, 1'b1};
      vecs[3] = '{1'b0, 3'd5, 3'd2, 2'd2, 3'd6, 3'd1, 1'b1};
      vecs[4] = '{1'b1, 3'd5, 3'd2, 2'd1, 3'd6, 3'd1, 1'b0};
      vecs[5] = '{1'b0, 3'd5, 3'd2, 2'd2, 3'd5, 3'd2, 1'b1};
      vecs[6] = '{1'b1, 3'd6, 3'd1, 2'd1, 3'd5, 3'd2, 1'b0};
      vecs[7] = '{1'b0, 3'd6, 3'd1, 2'd2, 3'd6, 3'd1, 1'b1};

      reset_L = 1'b0;
      init    = 1'b0;
      af_in   = 3'd6;
      ae_in   = 3'd1;
      bus.out_almost_full = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_rd_en", 32'(bus.rd_en), 32'd0);
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_af", 32'(af_out), 32'd0);
      check("rst_ae", 32'(ae_out), 32'd0);
      check("rst_idle", 32'(idle), 32'd0);

      // FSM / threshold table
      reset_L = 1'b1;
      for (int v = 0; v < 8; v++) begin
         init  = vecs[v].init;
         af_in = vecs[v].af;
         ae_in = vecs[v].ae;
         @(posedge clk); #1;
         check("vec_state", 32'(state), 32'(vecs[v].exp_state));
         check("vec_af", 32'(af_out), 32'(vecs[v].exp_af));
         check("vec_ae", 32'(ae_out), 32'(vecs[v].exp_ae));
         check("vec_idle", 32'(idle), 32'(vecs[v].exp_idle));
      end

      // Single word 0x2A5 from input 0
      gb = grant_log.size();
      wc = wr_count;
      push(0, 10'h2A5);
      wait_done(gb + 1, "single");
      check_order("single_order", gb, '{0, 0, 0, 0, 0, 0, 0, 0}, 1);
      check("single_writes", 32'(wr_count - wc), 32'd1);
      check("single_state", 32'(state), 32'd2);

      // All four inputs with two words each: back-to-back grants
      gb = grant_log.size();
      wc = wr_count;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < N_CH; c++) push(c, mk_word($urandom_range(0, 3)));
      wait_done(gb + 8, "burst");
      check_order("burst_order", gb, '{1, 2, 3, 0, 1, 2, 3, 0}, 8);
      check("burst_no_gap", 32'(grant_cyc[gb + 7] - grant_cyc[gb]), 32'd7);
      check("burst_writes", 32'(wr_count - wc), 32'd8);

      // Backpressure raised mid-stream
      gb = grant_log.size();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < N_CH; c++) push(c, mk_word($urandom_range(0, 3)));
      wait_grants(gb + 3, "bp");
      bus.out_almost_full = 4'b0010;
      wc = wr_count;
      #1;
      check("bp_rd_en_same_cycle", 32'(bus.rd_en), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("bp_no_grant", 32'(grant_log.size()), 32'(gb + 3));
      check("bp_drain", 32'(wr_count - wc), 32'd2);
      check("bp_state", 32'(state), 32'd3);
      bus.out_almost_full = '0;
      wait_done(gb + 8, "bp");
      check_order("bp_order", gb, '{1, 2, 3, 0, 1, 2, 3, 0}, 8);
      check("bp_resume_gap", 32'(grant_cyc[gb + 3] - grant_cyc[gb + 2]), 32'd6);

      // Data arrives while almost_full is already high: no grant
      gb = grant_log.size();
      bus.out_almost_full = 4'b1000;
      push(1, mk_word($urandom_range(0, 3)));
      repeat (4) @(posedge clk);
      #1;
      check("af_hold_no_grant", 32'(grant_log.size()), 32'(gb));
      check("af_hold_state", 32'(state), 32'd3);
      bus.out_almost_full = '0;
      wait_done(gb + 1, "af_hold");
      check_order("af_hold_order", gb, '{1, 0, 0, 0, 0, 0, 0, 0}, 1);

      // init raised while ACTIVE
      gb = grant_log.size();
      for (int r = 0; r < 3; r++) push(2, mk_word($urandom_range(0, 3)));
      wait_grants(gb + 1, "reinit");
      init  = 1'b1;
      af_in = 3'd5;
      ae_in = 3'd3;
      #1;
      check("reinit_rd_en", 32'(bus.rd_en), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("reinit_state", 32'(state), 32'd1);
      check("reinit_af", 32'(af_out), 32'd5);
      check("reinit_ae", 32'(ae_out), 32'd3);
      check("reinit_no_grant", 32'(grant_log.size()), 32'(gb + 1));
      init  = 1'b0;
      af_in = 3'd6;
      ae_in = 3'd1;
      wait_done(gb + 3, "reinit");
      check_order("reinit_order", gb, '{2, 2, 2, 0, 0, 0, 0, 0}, 3);

      // Reset with two words in flight
      gb = grant_log.size();
      for (int c = 0; c < N_CH; c++) push(c, mk_word($urandom_range(0, 3)));
      wait_grants(gb + 2, "midrst");
      reset_L = 1'b0;
      wc = wr_count;
      #1;
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_rd_en", 32'(bus.rd_en), 32'd0);
      check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
      check("midrst_out_data", 32'(bus.out_data), 32'd0);
      check("midrst_af", 32'(af_out), 32'd0);
      check("midrst_idle", 32'(idle), 32'd0);
      push(0, mk_word($urandom_range(0, 3)));
      repeat (2) @(posedge clk);
      #1;
      reset_L = 1'b1;
      gb = grant_log.size();
      wait_done(gb + 3, "midrst");
      check_order("midrst_order", gb, '{0, 1, 2, 0, 0, 0, 0, 0}, 3);
      check("midrst_writes", 32'(wr_count - wc), 32'd3);
      check("midrst_af_reload", 32'(af_out), 32'd6);

      // Inputs 0 and 3 competing
      gb = grant_log.size();
      for (int r = 0; r < 3; r++) begin
         push(0, mk_word($urandom_range(0, 3)));
         push(3, mk_word($urandom_range(0, 3)));
      end
      wait_done(gb + 6, "pair");
`ifdef ARB_STRICT_PRIO_EN
      check_order("pair_order", gb, '{0, 0, 0, 3, 3, 3, 0, 0}, 6);
`else
      check_order("pair_order", gb, '{3, 0, 3, 0, 3, 0, 0, 0}, 6);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_arbiter.md
Name: fifo_arbiter

Overview:
- Transaction-layer controller between four 10-bit input FIFOs and four destination FIFOs.
- Pops one word per cycle from the non-empty input FIFOs using round-robin arbitration.
- Routes each word by its destination field word[9:8] to the matching destination FIFO, and stalls on destination almost_full.
- Sequences init / idle / active operation and distributes the almost-full / almost-empty thresholds to the FIFOs.

Parameters:
- DATA_W, 10, word width; bits [DATA_W-1:DATA_W-2] are the destination field.
- N_CH, 4, number of input and destination FIFOs; fixed at 4, since the destination field is 2 bits.
- TH_W, 3, threshold width, matching the 3-bit FIFO pointers.

Ports:
- clk  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous active-low reset.
- init  in  1  request threshold (re)configuration.
- umbral_af_in  in  TH_W  almost-full threshold to program.
- umbral_ae_in  in  TH_W  almost-empty threshold to program.
- in_empty  in  N_CH  empty flag per input FIFO.
- in_data  in  N_CH*DATA_W  data_out of input FIFO i, at bits [i*DATA_W +: DATA_W].
- out_almost_full  in  N_CH  almost_full flag per destination FIFO.
- rd_en  out  N_CH  pop strobe per input FIFO; one-hot or zero.
- wr_en  out  N_CH  push strobe per destination FIFO; one-hot or zero.
- out_data  out  DATA_W  word presented to the destination FIFOs.
- umbral_af_out  out  TH_W  registered almost-full threshold driven to all FIFOs.
- umbral_ae_out  out  TH_W  registered almost-empty threshold driven to all FIFOs.
- state  out  2  current FSM state.
- idle  out  1  high when in IDLE and no word is in flight.

Behaviour:
- Reset values (reset_L=0, asynchronous): state=RESET, rd_en=0, wr_en=0, out_data=0, umbral_af_out=0, umbral_ae_out=0, idle=0, rr_last=3 (so input 0 wins first), pipeline valid bits cleared.
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
  - RESET: moves to INIT on the first clock after reset_L rises.
  - INIT: every cycle, umbral_*_out <= umbral_*_in. When init=0, moves to IDLE.
  - IDLE: init=1 moves to INIT. Otherwise, if any in_empty bit is 0, moves to ACTIVE; else stays.
  - ACTIVE: init=1 moves to INIT. Otherwise, if all in_empty are 1, moves to IDLE.
- Grant condition (combinational rd_en):
  - state==ACTIVE, init==0, and out_almost_full==0 (global backpressure).
  - Candidates are inputs with in_empty[i]==0.
  - Winner is the first candidate searching from rr_last+1 upward, modulo 4.
  - rd_en[winner]=1, and rr_last <= winner at that clock edge.
  - At most one rd_en bit per cycle; no grant means rd_en=0 and rr_last is held.
- Pipeline (in-flight limit of 2 words):
  - Cycle t: rd_en[i]=1.
  - Cycle t+1: the FIFO presents the word on slice i. The block registers that slice into out_data and sets wr_en <= onehot(word[9:8]) at the t+1 edge.
  - Cycle t+2: wr_en and out_data are valid for exactly 1 cycle. Fixed latency from rd_en to wr_en is 2 cycles.
  - With no word in flight: wr_en=0 and out_data holds its last value.
  - Back-to-back grants produce back-to-back writes, one per cycle.
- Backpressure: destination thresholds must leave ≥2 free entries. The block stops granting in the same cycle out_almost_full rises; words already in flight still complete.
- init asserted during ACTIVE: grants stop immediately, in-flight words drain normally, and thresholds update only while in INIT.
- Reset mid-operation: in-flight words are discarded, no wr_en is issued after reset_L falls, and rr_last returns to 3.
- idle = (state==IDLE) and both pipeline valid bits are 0.
- Simultaneous events:
  - init=1 together with data available: init wins and no grant is issued.
  - in_empty deasserting on the same cycle as out_almost_full: no grant.

Optional Feature:
- Macro: ARB_STRICT_PRIO_EN.
- Defined: the grant goes to the lowest-index non-empty input (input 0 highest priority), and rr_last is unused.
- Undefined: round-robin arbitration as specified above.
- Latency, backpressure and FSM are identical in both builds.

Test Plan:
- Reset, then init=1 with af=6, ae=1 for 2 cycles, then init=0 -> state passes 0→1→2; umbral_af_out=6, umbral_ae_out=1; idle=1.
- Input 0 holds one word 0x2A5 (dest 2) -> rd_en=0001 at cycle t; wr_en=0100 and out_data=0x2A5 at t+2; state returns to IDLE.
- All 4 inputs non-empty with 2 words each -> rd_en sequence 0001,0010,0100,1000,0001,... with no gaps; 8 writes on consecutive cycles.
- Same as the previous case with out_almost_full[1]=1 raised mid-stream -> rd_en=0 the same cycle, exactly ≤2 further wr_en pulses, and grants resume at the next round-robin index after the flag drops.
- reset_L pulsed low while 2 words are in flight -> no wr_en afterwards, all outputs at reset values, next grant goes to input 0.
- Built with ARB_STRICT_PRIO_EN, inputs 0 and 3 non-empty (3 words each) -> all 3 input-0 words are granted before any input-3 word.
